// File: rtl/cnn_mul_share_arb.sv
// rtl/cnn_mul_share_arb.sv - round-robin shared signed multiplier with tagged, backpressured response
// One multiplier time-shared by NUM_REQ lanes; the pipeline advances only when the output is free or consumed.
module cnn_mul_share_arb #(
  parameter int NUM_REQ     = 4,
  parameter int ID_WIDTH    = 2,
  parameter int DIN0_WIDTH  = 9,
  parameter int DIN1_WIDTH  = 14,
  parameter int DOUT_WIDTH  = 23,
  parameter int MUL_LATENCY = 2
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_din0,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_din1,
  output logic                             rsp_valid,
  output logic [ID_WIDTH-1:0]              rsp_id,
  output logic [DOUT_WIDTH-1:0]            rsp_dout,
  input  logic                             rsp_ready,
  output logic                             idle
);

  localparam int                LP_SW   = ID_WIDTH + 1;
  localparam logic [LP_SW-1:0]  LP_N    = LP_SW'(NUM_REQ);
  localparam logic [ID_WIDTH-1:0] LP_LAST = ID_WIDTH'(NUM_REQ - 1);

  logic [ID_WIDTH-1:0]   r_ptr;
  logic [MUL_LATENCY-1:0] r_vld;
  logic [ID_WIDTH-1:0]   r_id [MUL_LATENCY];
  logic [DIN0_WIDTH-1:0] r_a;
  logic [DIN1_WIDTH-1:0] r_b;

  logic                  w_en;
  logic                  w_found;
  logic                  w_acc;
  logic [ID_WIDTH-1:0]   w_gnt;
  logic [LP_SW-1:0]      w_sum;
  logic [DIN0_WIDTH-1:0] w_din0;
  logic [DIN1_WIDTH-1:0] w_din1;
  logic [DOUT_WIDTH-1:0] w_a_ext;
  logic [DOUT_WIDTH-1:0] w_b_ext;
  logic [DOUT_WIDTH-1:0] w_prod;

  assign rsp_valid = r_vld[MUL_LATENCY-1];
  assign rsp_id    = r_id[MUL_LATENCY-1];
  assign w_en      = !rsp_valid || rsp_ready;
  assign idle      = !(|r_vld) && !(|req_valid);

  // First valid lane at or above the pointer, wrapping past the last lane.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + LP_SW'(k);
      if (w_sum >= LP_N) w_sum = w_sum - LP_N;
      if (!w_found && req_valid[w_sum[ID_WIDTH-1:0]]) begin
        w_found = 1'b1;
        w_gnt   = w_sum[ID_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!ap_rst && w_en && w_found) req_ready[w_gnt] = 1'b1;
  end

  assign w_acc  = |(req_valid & req_ready);
  assign w_din0 = req_din0[w_gnt*DIN0_WIDTH +: DIN0_WIDTH];
  assign w_din1 = req_din1[w_gnt*DIN1_WIDTH +: DIN1_WIDTH];

  // Sign-extending both operands to the full product width keeps the low bits exact.
  assign w_a_ext = {{DIN1_WIDTH{r_a[DIN0_WIDTH-1]}}, r_a};
  assign w_b_ext = {{DIN0_WIDTH{r_b[DIN1_WIDTH-1]}}, r_b};
  assign w_prod  = w_a_ext * w_b_ext;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_ptr <= '0;
      r_vld <= '0;
      r_a   <= '0;
      r_b   <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) r_id[i] <= '0;
    end else begin
      if (w_acc) begin
        r_ptr <= (w_gnt == LP_LAST) ? '0 : w_gnt + 1'b1;
        r_a   <= w_din0;
        r_b   <= w_din1;
      end
      if (w_en) begin
        r_vld[0] <= w_acc;
        r_id[0]  <= w_gnt;
        for (int i = 1; i < MUL_LATENCY; i++) begin
          r_vld[i] <= r_vld[i-1];
          r_id[i]  <= r_id[i-1];
        end
      end
    end
  end

  generate
    if (MUL_LATENCY == 1) begin : g_lat1
      assign rsp_dout = w_prod;
    end else begin : g_latn
      logic [DOUT_WIDTH-1:0] r_p [1:MUL_LATENCY-1];
      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          for (int i = 1; i < MUL_LATENCY; i++) r_p[i] <= '0;
        end else if (w_en) begin
          r_p[1] <= w_prod;
          for (int i = 2; i < MUL_LATENCY; i++) r_p[i] <= r_p[i-1];
        end
      end
      assign rsp_dout = r_p[MUL_LATENCY-1];
    end
  endgenerate

endmodule

// File: tb/tb_cnn_mul_share_arb.sv
// tb/tb_cnn_mul_share_arb.sv - directed and random bench for cnn_mul_share_arb against a queue reference model
module tb_cnn_mul_share_arb;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int W0 = 9;
  localparam int W1 = 14;
  localparam int WO = 23;
  localparam int L  = 2;

  logic            ap_clk = 1'b0;
  logic            ap_rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W0-1:0] req_din0;
  logic [N*W1-1:0] req_din1;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [WO-1:0]   rsp_dout;
  logic            rsp_ready;
  logic            idle;

  always #5 ap_clk = ~ap_clk;

  cnn_mul_share_arb #(
    .NUM_REQ(N), .ID_WIDTH(IW), .DIN0_WIDTH(W0), .DIN1_WIDTH(W1),
    .DOUT_WIDTH(WO), .MUL_LATENCY(L)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_din0(req_din0), .req_din1(req_din1),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_dout(rsp_dout),
    .rsp_ready(rsp_ready), .idle(idle)
  );

  typedef struct {
    int     id;
    longint prod;
    int     rem;
  } op_t;

  int       checks = 0;
  int       errors = 0;
  int       opa [N];
  int       opb [N];
  op_t      q [$];
  int       m_ptr = 0;
  logic [N-1:0] exp_ready;
  logic     exp_vis;
  logic     exp_en;

  function automatic logic [WO-1:0] dv(input longint v);
    return v[WO-1:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      req_din0[i*W0 +: W0] = W0'(opa[i]);
      req_din1[i*W1 +: W1] = W1'(opb[i]);
    end
  endtask

  // Expected combinational behaviour from the model state and current inputs.
  task automatic model_outputs();
    int g;
    exp_vis   = (q.size() > 0) && (q[0].rem == 0);
    exp_en    = !exp_vis || rsp_ready;
    exp_ready = '0;
    if (!ap_rst && exp_en) begin
      for (int k = 0; k < N; k++) begin
        g = (m_ptr + k) % N;
        if (req_valid[g]) begin
          exp_ready[g] = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic tick();
    op_t e;
    @(negedge ap_clk);
    model_outputs();
    chk("req_ready", req_ready, exp_ready);
    chk("rsp_valid", rsp_valid, exp_vis);
    if (exp_vis) begin
      chk("rsp_id", rsp_id, q[0].id);
      chk("rsp_dout", rsp_dout, dv(q[0].prod));
    end
    chk("idle", idle, (q.size() == 0) && (req_valid == 0));
    @(posedge ap_clk);
    if (ap_rst) begin
      q.delete();
      m_ptr = 0;
    end else begin
      if (exp_en) begin
        if (exp_vis) void'(q.pop_front());
        foreach (q[i]) if (q[i].rem > 0) q[i].rem = q[i].rem - 1;
      end
      for (int g = 0; g < N; g++) begin
        if (exp_ready[g]) begin
          e.id   = g;
          e.prod = longint'(opa[g]) * longint'(opb[g]);
          e.rem  = L - 1;
          q.push_back(e);
          m_ptr = (g + 1) % N;
        end
      end
    end
    #1;
  endtask

  int ex_a [3] = '{-256, 255, 0};
  int ex_b [3] = '{-8192, 8191, -1};
  int ex_p [3] = '{2097152, 2088705, 0};
  int rr_p [4] = '{10, 40, 90, 160};
  int ptr_seq [3] = '{2, 8, 2};

  initial begin
    ap_rst    = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin opa[i] = 0; opb[i] = 0; end
    pack();
    @(posedge ap_clk);
    #1;
    tick();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_dout", rsp_dout, 0);
    chk("rst_rsp_id", rsp_id, 0);
    ap_rst = 1'b0;

    opa[2] = -256; opb[2] = 8191; pack();
    req_valid = 4'b0100;
    #1 chk("single_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    tick();
    chk("single_valid", rsp_valid, 1);
    chk("single_id", rsp_id, 2);
    chk("single_dout", rsp_dout, dv(-2096896));
    tick();
    chk("single_idle", idle, 1);

    for (int e = 0; e < 3; e++) begin
      opa[3] = ex_a[e]; opb[3] = ex_b[e]; pack();
      req_valid = 4'b1000;
      tick();
      req_valid = '0;
      tick();
      chk("ext_valid", rsp_valid, 1);
      chk("ext_dout", rsp_dout, dv(ex_p[e]));
      tick();
    end

    for (int i = 0; i < N; i++) begin opa[i] = i + 1; opb[i] = 10 * (i + 1); end
    pack();
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      #1 chk("rr_grant", req_ready, 1 << (c % 4));
      tick();
      if (c >= 1) chk("rr_prod", rsp_dout, dv(rr_p[(c - 1) % 4]));
    end
    req_valid = '0;
    repeat (3) tick();

    req_valid = 4'b0111;
    repeat (3) tick();
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1 chk("bp_ready", req_ready, 0);
      chk("bp_valid", rsp_valid, 1);
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    chk("bp_rel_valid", rsp_valid, 1);
    chk("bp_rel_id", rsp_id, 2);
    tick();
    chk("bp_drained", rsp_valid, 0);
    repeat (2) tick();

    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    req_valid = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      #1 chk("ptr_grant", req_ready, ptr_seq[c]);
      tick();
    end
    req_valid = 4'b0001;
    #1 chk("ptr_wrap", req_ready, 1);
    tick();
    req_valid = '0;
    repeat (3) tick();

    req_valid = '1;
    repeat (2) tick();
    ap_rst = 1'b1;
    #1 chk("rst_mid_ready", req_ready, 0);
    tick();
    chk("rst_mid_valid", rsp_valid, 0);
    chk("rst_mid_dout", rsp_dout, 0);
    chk("rst_mid_id", rsp_id, 0);
    ap_rst = 1'b0;
    req_valid = '0;
    repeat (4) tick();
    req_valid = 4'b1100;
    #1 chk("post_rst_grant", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    repeat (3) tick();

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        opa[i] = int'($urandom_range(0, 511)) - 256;
        opb[i] = int'($urandom_range(0, 16383)) - 8192;
      end
      pack();
      req_valid = N'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (6) tick();
    chk("final_idle", idle, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cnn_mul_share_arb.md
Name: cnn_mul_share_arb

Overview:
- Shares one signed 9x14 multiplier among NUM_REQ requesters, e.g. conv1 channel lanes.
- Round-robin arbitration, valid/ready request handshake, fixed-latency pipelined multiply, tagged single response port with backpressure.
- Sits between conv1 PE lanes and the DSP48 multiply resource. Lets HLS-generated lanes time-multiplex one DSP slice.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_WIDTH, 2, width of requester tag (clog2 NUM_REQ)
- DIN0_WIDTH, 9, signed operand A width
- DIN1_WIDTH, 14, signed operand B width
- DOUT_WIDTH, 23, signed product width (DIN0_WIDTH+DIN1_WIDTH)
- MUL_LATENCY, 2, pipeline stages from accept to response (>=1)

Ports:
- ap_clk  in  1  clock; all logic on rising edge
- ap_rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_din0  in  NUM_REQ*DIN0_WIDTH  packed signed A operands; lane i at [i*9 +: 9]
- req_din1  in  NUM_REQ*DIN1_WIDTH  packed signed B operands; lane i at [i*14 +: 14]
- rsp_valid  out  1  product valid
- rsp_id  out  ID_WIDTH  requester index of product
- rsp_dout  out  DOUT_WIDTH  signed product
- rsp_ready  in  1  downstream accepts product
- idle  out  1  high when no operation in flight and no req_valid

Behaviour:
- Reset (ap_rst high at clock edge): all pipeline valid bits 0, rsp_valid 0, rsp_id 0, rsp_dout 0, round-robin pointer 0.
  - req_ready is 0 while ap_rst is high.
  - In-flight operations are discarded, never emitted.
- Pipeline enable: en = !rsp_valid | rsp_ready. It stalls the whole pipeline, including bubbles; no bubble collapsing.
- Arbitration (combinational):
  - If en, grant goes to the first lane with req_valid set, searching from the pointer upward with wrap at NUM_REQ-1 -> 0.
  - req_ready[g] = 1 only for the granted lane; all others 0. req_ready must not depend on req_din*.
  - No valid lanes, or en=0: req_ready all 0.
- Accept: req_valid[g] & req_ready[g] at the clock edge.
  - Stage 1 captures din0/din1 of lane g, tag g, valid 1.
  - Pointer <= (g+1) mod NUM_REQ.
  - When nothing is accepted, the pointer holds.
- Multiply: full-precision signed product $signed(A)*$signed(B), exact, no truncation or saturation.
- Latency: an operation accepted at edge k appears on rsp_valid/rsp_id/rsp_dout after edge k+MUL_LATENCY-1, absent stalls. Each stall cycle adds one cycle.
- Throughput: one accept per cycle when rsp_ready is held high.
- Output hold: while rsp_valid=1 and rsp_ready=0, rsp_id/rsp_dout are stable and no accept occurs.
- Order: responses leave in accept order; each accept yields exactly one response.
- Fairness: with all lanes continuously valid and no stalls, grants rotate 0,1,2,3,0,... Each lane waits at most NUM_REQ-1 grants.
- idle = no valid bit in any stage, rsp_valid=0, and req_valid all 0.
- Simultaneous events:
  - An accept in the same cycle that the output is consumed is legal; both happen.
  - A requester dropping req_valid before accept is legal and loses nothing.

Test Plan:
- Single lane 2 valid with din0=-256, din1=8191, rsp_ready=1 -> req_ready[2] high same cycle; after MUL_LATENCY edges rsp_valid=1, rsp_id=2, rsp_dout=-2096896; idle returns 1.
- Extremes: din0=-256, din1=-8192 -> 2097152; din0=255, din1=8191 -> 2088705; din0=0, din1=-1 -> 0.
- All 4 lanes valid for 8 cycles, lane i operands (i+1, 10*(i+1)), rsp_ready=1 -> grant order 0,1,2,3,0,1,2,3; rsp_id follows same order with products 10,40,90,160 repeating.
- Backpressure: 3 accepts, then rsp_ready=0 for 5 cycles -> rsp_valid held with stable id/dout; req_ready all 0. Release -> remaining 2 responses on consecutive cycles in order, none lost or duplicated.
- Pointer: lanes 1 and 3 valid with pointer 0 -> grant 1, then 3, then 1. Lane 0 alone at pointer 2 -> grant 0 via wrap.
- Reset mid-operation: assert ap_rst with 2 operations in flight -> next cycle rsp_valid=0, rsp_dout=0, rsp_id=0, pointer 0; no stale response after release; first post-reset grant goes to lowest valid lane.
